// File: rtl/multicycle_sequencer_if.sv
// ----------------------------------------------------------------------------
// multicycle_sequencer_if
//
// Purpose: bundles every non-clock/reset signal of the rv32i multi-cycle
// control sequencer. The sequencer connects through the `slave` modport and
// the datapath, decoder and memory environment through the `master` modport.
//
// Handshake semantics (both instruction and data side):
//   *_req is raised by the sequencer and held high until the matching *_ack
//   arrives or the request times out. *_ack is a same-cycle completion: read
//   data is valid, or the store is done, in the cycle ack is high. An ack seen
//   while the matching req is low is ignored. There is no back-pressure on
//   ack and no data transfer outside req && ack.
//
// Signals:
//   run           environment -> seq  allow a new fetch to start
//   mem_op        decoder -> seq      memory operation code (2 bits)
//   jump_type     decoder -> seq      jump/branch type code (3 bits)
//   regfile_src   decoder -> seq      rd source code (3 bits)
//   funct3_valid  decoder -> seq      funct3 legality flag
//   imem_ack      imem -> seq         instruction fetch completion
//   dmem_ack      dmem -> seq         data access completion
//   imem_req      seq -> imem         instruction fetch request
//   dmem_req      seq -> dmem         data access request
//   dmem_we       seq -> dmem         1 = store, qualified by dmem_req
//   ir_we         seq -> datapath     latch instruction register
//   alu_we        seq -> datapath     latch ALU result register
//   mdr_we        seq -> datapath     latch load data register
//   pc_we         seq -> datapath     update PC
//   regfile_we    seq -> datapath     write rd
//   retire        seq -> observers    one pulse per completed instruction
//   halted        seq -> observers    sequencer is in TRAP
//   trap_cause    seq -> observers    00 none, 01 illegal, 10 fetch timeout,
//                                     11 data timeout
//   state         seq -> observers    current FSM state (debug visibility)
//   cycle_count   seq -> observers    only with SEQ_PERF_COUNTERS_EN
//   instret_count seq -> observers    only with SEQ_PERF_COUNTERS_EN
//
// Optional feature macro: SEQ_PERF_COUNTERS_EN
// ----------------------------------------------------------------------------
interface multicycle_sequencer_if;

    logic       run;
    logic [1:0] mem_op;
    logic [2:0] jump_type;
    logic [2:0] regfile_src;
    logic       funct3_valid;
    logic       imem_ack;
    logic       dmem_ack;

    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_we;
    logic       alu_we;
    logic       mdr_we;
    logic       pc_we;
    logic       regfile_we;
    logic       retire;
    logic       halted;
    logic [1:0] trap_cause;
    logic [2:0] state;

`ifdef SEQ_PERF_COUNTERS_EN
    logic [31:0] cycle_count;
    logic [31:0] instret_count;

    modport slave (
        input  run, mem_op, jump_type, regfile_src, funct3_valid,
        input  imem_ack, dmem_ack,
        output imem_req, dmem_req, dmem_we,
        output ir_we, alu_we, mdr_we, pc_we, regfile_we,
        output retire, halted, trap_cause, state,
        output cycle_count, instret_count
    );

    modport master (
        output run, mem_op, jump_type, regfile_src, funct3_valid,
        output imem_ack, dmem_ack,
        input  imem_req, dmem_req, dmem_we,
        input  ir_we, alu_we, mdr_we, pc_we, regfile_we,
        input  retire, halted, trap_cause, state,
        input  cycle_count, instret_count
    );
`else
    modport slave (
        input  run, mem_op, jump_type, regfile_src, funct3_valid,
        input  imem_ack, dmem_ack,
        output imem_req, dmem_req, dmem_we,
        output ir_we, alu_we, mdr_we, pc_we, regfile_we,
        output retire, halted, trap_cause, state
    );

    modport master (
        output run, mem_op, jump_type, regfile_src, funct3_valid,
        output imem_ack, dmem_ack,
        input  imem_req, dmem_req, dmem_we,
        input  ir_we, alu_we, mdr_we, pc_we, regfile_we,
        input  retire, halted, trap_cause, state
    );
`endif

endinterface

// File: rtl/multicycle_sequencer.sv
// ----------------------------------------------------------------------------
// multicycle_sequencer
//
// Purpose: multi-cycle control FSM for the rv32i core. Steps one instruction
// at a time through FETCH -> DECODE -> EXECUTE -> (MEM) -> WRITEBACK, raising
// the datapath write strobes and the instruction/data memory requests. An
// illegal decode or a memory request left unacknowledged for MEM_TIMEOUT
// cycles parks the sequencer in TRAP until reset.
//
// Parameters:
//   MEM_TIMEOUT  cycles a request may stay unacknowledged (legal 2..255)
//   TMR_W        wait counter width, 2**TMR_W must exceed MEM_TIMEOUT
//
// Ports:
//   clk    core clock, rising edge
//   reset  synchronous, active-high
//   bus    multicycle_sequencer_if.slave (decoder fields, run, acks in;
//          requests, strobes, retire/halted/trap_cause/state out)
//
// Optional feature macro: SEQ_PERF_COUNTERS_EN
//   Adds bus.cycle_count (counts every non-halted cycle) and
//   bus.instret_count (counts retired instructions); both wrap mod 2**32.
//
// State encoding on bus.state:
//   FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, TRAP=5
//
// Timing with zero-wait memory, FETCH to FETCH:
//   ALU / branch / jump = 4 cycles, load / store = 5 cycles.
// ----------------------------------------------------------------------------
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TMR_W       = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_sequencer_if.slave   bus
);

    // Decoder codes shared with the rest of the core. Only the codes this
    // block acts on are listed (JAL/JALR and the non-NONE register sources
    // all take the default path).
    localparam logic [1:0] MEM_OP_NONE  = 2'd0;
    localparam logic [1:0] MEM_OP_LOAD  = 2'd1;
    localparam logic [1:0] MEM_OP_STORE = 2'd2;

    localparam logic [2:0] JUMP_NONE    = 3'd0;
    localparam logic [2:0] JUMP_IF_0    = 3'd3;
    localparam logic [2:0] JUMP_IF_1    = 3'd4;

    localparam logic [2:0] REG_SRC_NONE = 3'd0;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_FETCH   = 2'b10;
    localparam logic [1:0] TRAP_DATA    = 2'b11;

    // Counter value of the last request cycle that may still be acknowledged.
    localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(MEM_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] WAIT_ZERO = '0;
    localparam logic [TMR_W-1:0] WAIT_ONE  = TMR_W'(1);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [TMR_W-1:0] wait_q,  wait_d;
    logic [1:0]       trap_q,  trap_d;

    // Decoder fields captured at the end of DECODE. EXECUTE, MEM and
    // WRITEBACK decode from these copies so that no decoder input reaches
    // an output combinationally.
    logic [1:0]       mem_op_q;
    logic [2:0]       jump_q;
    logic [2:0]       src_q;

    // ------------------------------------------------------------------
    // Request/acknowledge qualification shared by next-state and outputs
    // ------------------------------------------------------------------
    logic fetch_req;
    logic fetch_ack;
    logic data_req;
    logic data_ack;
    logic wait_expired;
    logic illegal;

    // run only matters before the request is raised; once the counter has
    // moved the fetch request is committed until ack or timeout.
    assign fetch_req    = (state_q == S_FETCH) &&
                          ((wait_q == WAIT_ZERO) ? bus.run : 1'b1);
    assign fetch_ack    = fetch_req && bus.imem_ack;
    assign data_req     = (state_q == S_MEM);
    assign data_ack     = data_req && bus.dmem_ack;
    assign wait_expired = (wait_q == WAIT_LAST);

    // Funct3 is illegal, or the instruction does nothing at all.
    assign illegal = !bus.funct3_valid ||
                     ((bus.mem_op      == MEM_OP_NONE) &&
                      (bus.jump_type   == JUMP_NONE)   &&
                      (bus.regfile_src == REG_SRC_NONE));

    // ------------------------------------------------------------------
    // Process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            wait_q  <= WAIT_ZERO;
            trap_q  <= TRAP_NONE;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            trap_q  <= trap_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_op_q <= MEM_OP_NONE;
            jump_q   <= JUMP_NONE;
            src_q    <= REG_SRC_NONE;
        end else if (state_q == S_DECODE) begin
            mem_op_q <= bus.mem_op;
            jump_q   <= bus.jump_type;
            src_q    <= bus.regfile_src;
        end
    end

    // ------------------------------------------------------------------
    // Process 2: next-state logic
    // The wait counter returns to zero on every state change, so each
    // request starts its timeout window fresh.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        trap_d  = trap_q;

        unique case (state_q)
            S_FETCH: begin
                if (fetch_ack) begin
                    state_d = S_DECODE;
                    wait_d  = WAIT_ZERO;
                end else if (fetch_req) begin
                    if (wait_expired) begin
                        state_d = S_TRAP;
                        trap_d  = TRAP_FETCH;
                        wait_d  = WAIT_ZERO;
                    end else begin
                        wait_d  = wait_q + WAIT_ONE;
                    end
                end
                // run low with no request outstanding: park, counter stays 0
            end

            S_DECODE: begin
                wait_d = WAIT_ZERO;
                if (illegal) begin
                    state_d = S_TRAP;
                    trap_d  = TRAP_ILLEGAL;
                end else begin
                    state_d = S_EXECUTE;
                end
            end

            S_EXECUTE: begin
                wait_d = WAIT_ZERO;
                if ((mem_op_q == MEM_OP_LOAD) || (mem_op_q == MEM_OP_STORE)) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end

            S_MEM: begin
                // Ack in the last permitted cycle still completes the access.
                if (data_ack) begin
                    state_d = S_WRITEBACK;
                    wait_d  = WAIT_ZERO;
                end else if (wait_expired) begin
                    state_d = S_TRAP;
                    trap_d  = TRAP_DATA;
                    wait_d  = WAIT_ZERO;
                end else begin
                    wait_d  = wait_q + WAIT_ONE;
                end
            end

            S_WRITEBACK: begin
                state_d = S_FETCH;
                wait_d  = WAIT_ZERO;
            end

            S_TRAP: begin
                // Sticky until reset; trap_cause is frozen.
                wait_d = WAIT_ZERO;
            end

            default: begin
                // Unused encodings recover to a clean fetch.
                state_d = S_FETCH;
                wait_d  = WAIT_ZERO;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Process 3: output decode from registered state (plus acks and run)
    // ------------------------------------------------------------------
    logic imem_req_c;
    logic dmem_req_c;
    logic dmem_we_c;
    logic ir_we_c;
    logic alu_we_c;
    logic mdr_we_c;
    logic pc_we_c;
    logic regfile_we_c;
    logic retire_c;
    logic halted_c;

    always_comb begin
        imem_req_c   = 1'b0;
        dmem_req_c   = 1'b0;
        dmem_we_c    = 1'b0;
        ir_we_c      = 1'b0;
        alu_we_c     = 1'b0;
        mdr_we_c     = 1'b0;
        pc_we_c      = 1'b0;
        regfile_we_c = 1'b0;
        retire_c     = 1'b0;
        halted_c     = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                imem_req_c = fetch_req;
                ir_we_c    = fetch_ack;
            end

            S_DECODE: begin
            end

            S_EXECUTE: begin
                alu_we_c = 1'b1;
            end

            S_MEM: begin
                dmem_req_c = data_req;
                dmem_we_c  = (mem_op_q == MEM_OP_STORE);
                mdr_we_c   = data_ack && (mem_op_q == MEM_OP_LOAD);
            end

            S_WRITEBACK: begin
                pc_we_c  = 1'b1;
                retire_c = 1'b1;
                // Branches report PCP4 as their source; they must not write rd.
                regfile_we_c = (src_q    != REG_SRC_NONE) &&
                               (jump_q   != JUMP_IF_0)    &&
                               (jump_q   != JUMP_IF_1)    &&
                               (mem_op_q != MEM_OP_STORE);
            end

            S_TRAP: begin
                halted_c = 1'b1;
            end

            default: begin
            end
        endcase
    end

    assign bus.imem_req   = imem_req_c;
    assign bus.dmem_req   = dmem_req_c;
    assign bus.dmem_we    = dmem_we_c;
    assign bus.ir_we      = ir_we_c;
    assign bus.alu_we     = alu_we_c;
    assign bus.mdr_we     = mdr_we_c;
    assign bus.pc_we      = pc_we_c;
    assign bus.regfile_we = regfile_we_c;
    assign bus.retire     = retire_c;
    assign bus.halted     = halted_c;
    assign bus.trap_cause = trap_q;
    assign bus.state      = state_q;

`ifdef SEQ_PERF_COUNTERS_EN
    // ------------------------------------------------------------------
    // Performance counters, free-running modulo 2**32
    // ------------------------------------------------------------------
    logic [31:0] cycle_q;
    logic [31:0] instret_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q   <= 32'd0;
            instret_q <= 32'd0;
        end else begin
            if (state_q != S_TRAP) begin
                cycle_q <= cycle_q + 32'd1;
            end
            if (state_q == S_WRITEBACK) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    assign bus.cycle_count   = cycle_q;
    assign bus.instret_count = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// ----------------------------------------------------------------------------
// tb_multicycle_sequencer
//
// Self-checking bench for multicycle_sequencer. A directed vector table and a
// randomized instruction stream are driven through one driver task; a
// transaction-level reference model turns each instruction's decoder fields
// and memory wait counts into the expected per-cycle state sequence and the
// expected number of pulses on every strobe. Hand-written sequences cover
// run gating, trap persistence and reset in the middle of a data request.
// ----------------------------------------------------------------------------
module tb_multicycle_sequencer;

    localparam int TMO = 16;
    localparam int NEVER = 255;   // wait count that can never be reached

    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;
    localparam logic [2:0] J_NONE   = 3'd0;
    localparam logic [2:0] J_JAL    = 3'd1;
    localparam logic [2:0] J_IF0    = 3'd3;
    localparam logic [2:0] J_IF1    = 3'd4;
    localparam logic [2:0] SRC_NONE = 3'd0;
    localparam logic [2:0] SRC_ALU  = 3'd1;
    localparam logic [2:0] SRC_MEM  = 3'd2;
    localparam logic [2:0] SRC_PCP4 = 3'd3;

    localparam logic [2:0] ST_F = 3'd0;
    localparam logic [2:0] ST_D = 3'd1;
    localparam logic [2:0] ST_E = 3'd2;
    localparam logic [2:0] ST_M = 3'd3;
    localparam logic [2:0] ST_W = 3'd4;
    localparam logic [2:0] ST_T = 3'd5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_sequencer_if bus();

    multicycle_sequencer #(
        .MEM_TIMEOUT(TMO),
        .TMR_W      (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        int cycles;
        int ir, alu, mdr, pc, rf, retire;
        int ireq, dreq, dwe;
        int trap;
    } res_t;

    logic [2:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Works from the instruction-level rules: how many cycles each phase
    // lasts for given ack delays, and which strobes the instruction earns.
    task automatic model(input logic [1:0] m, input logic [2:0] j, input logic [2:0] s,
                         input logic f, input int iw, input int dw, output res_t e);
        bit is_mem;
        e = '{default: 0};
        exp_q.delete();
        if (iw >= TMO) begin
            repeat (TMO) exp_q.push_back(ST_F);
            e.ireq = TMO; e.trap = 2; e.cycles = exp_q.size();
            return;
        end
        repeat (iw + 1) exp_q.push_back(ST_F);
        e.ireq = iw + 1; e.ir = 1;
        exp_q.push_back(ST_D);
        if (!f || (m == OP_NONE && j == J_NONE && s == SRC_NONE)) begin
            e.trap = 1; e.cycles = exp_q.size();
            return;
        end
        exp_q.push_back(ST_E);
        e.alu = 1;
        is_mem = (m == OP_LOAD) || (m == OP_STORE);
        if (is_mem) begin
            if (dw >= TMO) begin
                repeat (TMO) exp_q.push_back(ST_M);
                e.dreq = TMO; e.dwe = (m == OP_STORE) ? TMO : 0;
                e.trap = 3; e.cycles = exp_q.size();
                return;
            end
            repeat (dw + 1) exp_q.push_back(ST_M);
            e.dreq = dw + 1; e.dwe = (m == OP_STORE) ? dw + 1 : 0;
            e.mdr = (m == OP_LOAD) ? 1 : 0;
        end
        exp_q.push_back(ST_W);
        e.pc = 1; e.retire = 1;
        e.rf = (s != SRC_NONE && j != J_IF0 && j != J_IF1 && m != OP_STORE) ? 1 : 0;
        e.cycles = exp_q.size();
    endtask

    // ---------------- driver tasks ----------------
    // Enters with the DUT in FETCH with an idle wait counter; returns at a
    // falling edge once the next FETCH (or TRAP) is reached.
    task automatic run_instr(input string tag, input logic [1:0] m, input logic [2:0] j,
                             input logic [2:0] s, input logic f, input int iw, input int dw,
                             input bit spur, output res_t o);
        res_t e;
        int ic, dc, guard;
        bit retired;
        logic [2:0] st;
        model(m, j, s, f, iw, dw, e);
        o = '{default: 0};
        ic = 0; dc = 0; guard = 0; retired = 0;
        bus.run = 1'b1; bus.mem_op = m; bus.jump_type = j;
        bus.regfile_src = s; bus.funct3_valid = f;
        while (guard < 400) begin
            st = bus.state;
            if (st == ST_T) break;
            if (st == ST_F && retired) break;
            bus.imem_ack = (st == ST_F) ? (ic == iw) : (spur ? 1'($urandom_range(0, 1)) : 1'b0);
            bus.dmem_ack = (st == ST_M) ? (dc == dw) : (spur ? 1'($urandom_range(0, 1)) : 1'b0);
            #1;
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL %s state_seq: extra cycle in state %0d", tag, st);
            end else begin
                check({tag, " state_seq"}, st, exp_q.pop_front());
            end
            o.cycles++;
            o.ir     += int'(bus.ir_we);
            o.alu    += int'(bus.alu_we);
            o.mdr    += int'(bus.mdr_we);
            o.pc     += int'(bus.pc_we);
            o.rf     += int'(bus.regfile_we);
            o.retire += int'(bus.retire);
            o.ireq   += int'(bus.imem_req);
            o.dreq   += int'(bus.dmem_req);
            o.dwe    += int'(bus.dmem_req && bus.dmem_we);
            if (bus.imem_req) ic++;
            if (bus.dmem_req) dc++;
            if (bus.retire) retired = 1;
            @(negedge clk);
            guard++;
        end
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        if (guard >= 400) begin
            checks++; failures++;
            $display("FAIL %s budget: instruction did not finish in 400 cycles", tag);
        end
        o.trap = int'(bus.trap_cause);
        check({tag, " seq_remaining"}, exp_q.size(), 0);
        check({tag, " cycles"}, o.cycles, e.cycles);
        check({tag, " ir_we"},  o.ir,  e.ir);
        check({tag, " alu_we"}, o.alu, e.alu);
        check({tag, " mdr_we"}, o.mdr, e.mdr);
        check({tag, " pc_we"},  o.pc,  e.pc);
        check({tag, " regfile_we"}, o.rf, e.rf);
        check({tag, " retire"}, o.retire, e.retire);
        check({tag, " imem_req_cycles"}, o.ireq, e.ireq);
        check({tag, " dmem_req_cycles"}, o.dreq, e.dreq);
        check({tag, " dmem_we_cycles"},  o.dwe,  e.dwe);
        check({tag, " trap_cause"}, o.trap, e.trap);
        check({tag, " halted"}, bus.halted, (e.trap != 0));
    endtask

    // Pulses reset for one edge and checks the first cycle after it.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check({tag, " rst state"},      bus.state, ST_F);
        check({tag, " rst trap_cause"}, bus.trap_cause, 0);
        check({tag, " rst halted"},     bus.halted, 0);
        check({tag, " rst imem_req"},   bus.imem_req, bus.run);
        check({tag, " rst dmem_req"},   bus.dmem_req, 0);
        check({tag, " rst dmem_we"},    bus.dmem_we, 0);
        check({tag, " rst strobes"},
              {bus.ir_we, bus.alu_we, bus.mdr_we, bus.pc_we, bus.regfile_we, bus.retire}, 0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0] m;
        logic [2:0] j;
        logic [2:0] s;
        logic       f;
        int         iw;
        int         dw;
        int         exp_cycles;
        int         exp_rf;
        int         exp_trap;
        int         exp_dreq;
    } vec_t;

    vec_t vecs[14];

    initial begin
        res_t o;
        logic [1:0] rm;
        logic [2:0] rj, rs;
        logic rf3;
        int riw, rdw, mcount;

        //        m         j       s         f     iw     dw    cyc rf trap dreq
        vecs[0]  = '{OP_NONE,  J_NONE, SRC_ALU,  1'b1, 0,     0,     4,  1, 0, 0};   // ADD
        vecs[1]  = '{OP_LOAD,  J_NONE, SRC_MEM,  1'b1, 0,     3,     8,  1, 0, 4};   // LW, 3 wait
        vecs[2]  = '{OP_STORE, J_NONE, SRC_NONE, 1'b1, 0,     0,     5,  0, 0, 1};   // SW
        vecs[3]  = '{OP_NONE,  J_IF0,  SRC_PCP4, 1'b1, 0,     0,     4,  0, 0, 0};   // BEQ
        vecs[4]  = '{OP_NONE,  J_IF1,  SRC_PCP4, 1'b1, 0,     0,     4,  0, 0, 0};   // BNE
        vecs[5]  = '{OP_NONE,  J_JAL,  SRC_PCP4, 1'b1, 0,     0,     4,  1, 0, 0};   // JAL
        vecs[6]  = '{OP_STORE, J_NONE, SRC_ALU,  1'b1, 0,     0,     5,  0, 0, 1};   // store suppresses rd
        vecs[7]  = '{OP_NONE,  J_NONE, SRC_ALU,  1'b1, 5,     0,     9,  1, 0, 0};   // slow fetch
        vecs[8]  = '{OP_NONE,  J_NONE, SRC_ALU,  1'b1, 15,    0,     19, 1, 0, 0};   // ack on last fetch cycle
        vecs[9]  = '{OP_STORE, J_NONE, SRC_NONE, 1'b1, 0,     15,    20, 0, 0, 16};  // ack on last data cycle
        vecs[10] = '{OP_NONE,  J_NONE, SRC_ALU,  1'b0, 0,     0,     2,  0, 1, 0};   // bad funct3
        vecs[11] = '{OP_NONE,  J_NONE, SRC_NONE, 1'b1, 0,     0,     2,  0, 1, 0};   // no-effect instr
        vecs[12] = '{OP_NONE,  J_NONE, SRC_ALU,  1'b1, NEVER, 0,     16, 0, 2, 0};   // fetch timeout
        vecs[13] = '{OP_LOAD,  J_NONE, SRC_MEM,  1'b1, 0,     NEVER, 19, 0, 3, 16};  // data timeout

        reset = 1'b1;
        bus.run = 1'b0; bus.mem_op = OP_NONE; bus.jump_type = J_NONE;
        bus.regfile_src = SRC_NONE; bus.funct3_valid = 1'b1;
        bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
        repeat (2) @(negedge clk);

        // ---- run low after reset: parked, acks ignored ----
        do_reset("init");
        bus.imem_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("park imem_req", bus.imem_req, 0);
            check("park state", bus.state, ST_F);
            check("park ir_we", bus.ir_we, 0);
            @(negedge clk);
            #1;
        end
        bus.imem_ack = 1'b0;
        @(negedge clk);
        run_instr("after_park", OP_NONE, J_NONE, SRC_ALU, 1'b1, 0, 0, 1'b0, o);
        // back-to-back instruction with no reset in between
        run_instr("b2b", OP_LOAD, J_NONE, SRC_MEM, 1'b1, 2, 1, 1'b0, o);

        // ---- table-driven vectors ----
        for (int i = 0; i < 14; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run_instr(tag, vecs[i].m, vecs[i].j, vecs[i].s, vecs[i].f,
                      vecs[i].iw, vecs[i].dw, 1'b0, o);
            check({tag, " tbl_cycles"}, o.cycles, vecs[i].exp_cycles);
            check({tag, " tbl_rf"},     o.rf,     vecs[i].exp_rf);
            check({tag, " tbl_trap"},   o.trap,   vecs[i].exp_trap);
            check({tag, " tbl_dreq"},   o.dreq,   vecs[i].exp_dreq);
            if (bus.state != ST_F) do_reset(tag);
        end

        // ---- run dropped after the fetch request is raised ----
        bus.mem_op = OP_NONE; bus.jump_type = J_NONE;
        bus.regfile_src = SRC_ALU; bus.funct3_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.run = (i < 3);
            bus.imem_ack = (i == 4);
            #1;
            check("rundrop imem_req", bus.imem_req, 1);
            check("rundrop ir_we", bus.ir_we, (i == 4));
            @(negedge clk);
        end
        bus.imem_ack = 1'b0;
        check("rundrop state", bus.state, ST_D);
        bus.run = 1'b1;
        do_reset("rundrop");

        // ---- illegal instruction: trap persists, acks ignored ----
        run_instr("trap_hold", OP_NONE, J_NONE, SRC_ALU, 1'b0, 0, 0, 1'b0, o);
        bus.imem_ack = 1'b1; bus.dmem_ack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            check("trap halted", bus.halted, 1);
            check("trap state", bus.state, ST_T);
            check("trap cause", bus.trap_cause, 1);
            check("trap reqs", {bus.imem_req, bus.dmem_req}, 0);
            check("trap strobes",
                  {bus.ir_we, bus.alu_we, bus.mdr_we, bus.pc_we, bus.regfile_we, bus.retire}, 0);
            @(negedge clk);
        end
        do_reset("trap_exit");

        // ---- reset while a load request is outstanding ----
        bus.run = 1'b1; bus.mem_op = OP_LOAD; bus.jump_type = J_NONE;
        bus.regfile_src = SRC_MEM; bus.funct3_valid = 1'b1;
        mcount = 0;
        for (int i = 0; i < 20 && mcount < 3; i++) begin
            bus.imem_ack = (bus.state == ST_F);
            bus.dmem_ack = 1'b0;
            #1;
            if (bus.state == ST_M) mcount++;
            @(negedge clk);
        end
        bus.imem_ack = 1'b0;
        #1;
        check("midmem dmem_req before reset", bus.dmem_req, 1);
        do_reset("midmem");

        // ---- randomized stream against the reference model ----
        for (int n = 0; n < 60; n++) begin
            rm  = 2'($urandom_range(0, 3));
            rj  = 3'($urandom_range(0, 7));
            rs  = 3'($urandom_range(0, 5));
            rf3 = ($urandom_range(0, 7) != 0);
            riw = ($urandom_range(0, 11) == 0) ? NEVER : int'($urandom_range(0, 4));
            rdw = ($urandom_range(0, 11) == 0) ? NEVER : int'($urandom_range(0, 4));
            if ($urandom_range(0, 9) == 0) riw = TMO - 1;
            if ($urandom_range(0, 9) == 0) rdw = TMO - 1;
            run_instr($sformatf("rnd%0d", n), rm, rj, rs, rf3, riw, rdw, 1'b1, o);
            if (bus.state != ST_F) do_reset($sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the bench can never hang.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
Multi-cycle control FSM for the rv32i core. Drives one instruction at a time through FETCH, DECODE, EXECUTE, MEM and WRITEBACK. Consumes the decoder's mem_op, jump_type, regfile_src and funct3_valid fields. Produces the datapath write strobes and the instruction/data memory request handshakes, with illegal-instruction and bus-timeout trapping.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory request is held without ack before trapping; legal range 2..255.
TMR_W, 8, width of the internal wait counter; must satisfy 2^TMR_W > MEM_TIMEOUT.

Ports:
clk  in  1  core clock, all state updates on rising edge
reset  in  1  synchronous, active-high; state and outputs return to reset values on the next rising edge
run  in  1  1 = allowed to start a new fetch; 0 = park in FETCH
mem_op  in  2  decoder memory operation (MEM_OP_NONE/LOAD/STORE codes from defines.v)
jump_type  in  3  decoder jump type (JUMP_NONE/JAL/JALR/IF_0/IF_1 codes)
regfile_src  in  3  decoder rd source (REG_SRC_* codes)
funct3_valid  in  1  decoder funct3 legality flag
imem_ack  in  1  instruction memory ack; data valid same cycle
dmem_ack  in  1  data memory ack; load data valid / store done same cycle
imem_req  out  1  instruction fetch request
dmem_req  out  1  data access request
dmem_we  out  1  1 = store, valid while dmem_req
ir_we  out  1  latch instruction register
alu_we  out  1  latch ALU result register
mdr_we  out  1  latch load data register
pc_we  out  1  update PC (next-PC mux handled by datapath from jump_type)
regfile_we  out  1  write rd
retire  out  1  one-cycle pulse per completed instruction
halted  out  1  sequencer in TRAP
trap_cause  out  2  00 none, 01 illegal, 10 fetch timeout, 11 data timeout
state  out  3  current state: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, TRAP=5

Behaviour:
- Reset: state=FETCH, wait counter=0, trap_cause=00. All strobes, imem_req, dmem_req, dmem_we, retire and halted are 0 in the first cycle after reset, except imem_req=run.
- Outputs are decoded from registered state plus the ack inputs. The only combinational input→output paths are ack→ir_we/mdr_we and run→imem_req.
- FETCH:
  - imem_req=run.
  - With run=0: stay in FETCH; counter held at 0.
  - With run=1 and imem_ack=1: ir_we=1; next state DECODE.
  - With run=1 and no ack: counter increments. When counter==MEM_TIMEOUT-1 and still no ack: trap_cause=10, next state TRAP.
  - imem_req stays high until ack or timeout. Deasserting run mid-request is ignored once req is raised; run is only sampled while counter==0.
- DECODE (1 cycle):
  - illegal = !funct3_valid OR (mem_op==NONE AND jump_type==JUMP_NONE AND regfile_src==REG_SRC_NONE).
  - illegal → trap_cause=01, TRAP; otherwise → EXECUTE.
- EXECUTE (1 cycle): alu_we=1. Next state MEM if mem_op is LOAD or STORE, else WRITEBACK.
- MEM:
  - dmem_req=1; dmem_we=1 iff STORE.
  - On dmem_ack: mdr_we=1 for loads only; next state WRITEBACK.
  - Same timeout rule as FETCH; on timeout trap_cause=11.
  - Counter clears on every state entry.
- WRITEBACK (1 cycle):
  - pc_we=1, retire=1.
  - regfile_we=1 iff regfile_src!=NONE AND jump_type not JUMP_IF_0/JUMP_IF_1 AND mem_op!=STORE. The decoder reports PCP4 for branches; the sequencer must suppress that write.
  - Next state FETCH.
- TRAP: halted=1; all strobes and requests 0; trap_cause frozen; exit only by reset.
- Acks arriving while the corresponding req=0 are ignored. A simultaneous imem_ack and dmem_ack is resolved by state (only the one matching the current request counts).
- Latency with zero-wait memory (ack in first request cycle): ALU/branch/jump = 4 cycles, load/store = 5 cycles, FETCH to FETCH.
- Reset asserted mid-operation (any state, including with req high): next edge forces FETCH, and no strobe fires in the reset cycle's successor except imem_req=run.

Optional Feature:
SEQ_PERF_COUNTERS_EN: adds outputs cycle_count[31:0] and instret_count[31:0].
- Both reset to 0.
- cycle_count increments every cycle while not halted; instret_count increments on retire.
- Both wrap modulo 2^32.
- Without the macro, the ports and logic are absent.

Test Plan:
- Reset, run=1, ack in first request cycle, ADD decode (mem_op=NONE, jump=NONE, src=ALU) → state sequence 0,1,2,4,0; ir_we, alu_we, pc_we, regfile_we, retire each high exactly once; 4 cycles.
- LOAD with dmem_ack delayed 3 cycles → dmem_req high 4 cycles, dmem_we=0, mdr_we on ack cycle, regfile_we in WRITEBACK; total 8 cycles.
- STORE and BEQ (jump=IF_0, src=PCP4) → regfile_we=0 in WRITEBACK; store shows dmem_we=1; pc_we=1 and retire=1 for both.
- funct3_valid=0 in DECODE → TRAP next cycle, trap_cause=01, halted=1 held 20 cycles; reset → FETCH, trap_cause=00.
- imem_ack never asserted, MEM_TIMEOUT=16 → imem_req high exactly 16 cycles, then TRAP with trap_cause=10; repeat on data side → 11.
- run=0 after reset for 10 cycles → imem_req=0, state=0 throughout; reset pulsed during MEM with dmem_req high → dmem_req=0 and state=0 after the edge.
